// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: shared state encoding, default width and counter sizing.
package seq_restoring_divider_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DZERO} state_e;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/seq_restoring_divider_sub_stage.sv
// div_sub_stage: ripple chain of full subtractors forming the trial difference A' - M.
module div_sub_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] t_o,
  output logic             nonneg_o
);
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] bw;
  logic [WIDTH:0]   b;
  assign b     = {1'b0, m_i};
  assign bw[0] = 1'b0;
  for (genvar i = 0; i <= WIDTH; i++) begin : g_fs
    assign diff[i]  = a_i[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a_i[i] & b[i]) | (~(a_i[i] ^ b[i]) & bw[i]);
  end
  // A' < 2M always holds, so a clear top difference bit means the trial succeeded
  assign t_o      = diff[WIDTH-1:0];
  assign nonneg_o = ~diff[WIDTH];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider, one quotient bit per clock.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d, quot_q, quot_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d, dz_q, dz_d;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] t;
  logic             nonneg, last, accept;
  // remainder stays below M, so A needs no guard bit between iterations
  assign a_sh   = {a_q, q_q[WIDTH-1]};
  assign last   = cnt_q == CW'(1);
  assign accept = state_q == IDLE && start;
  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .a_i      (a_sh),
    .m_i      (m_q),
    .t_o      (t),
    .nonneg_o (nonneg)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? (|divisor ? CALC : DZERO) : IDLE) :
              state_q == CALC ? (last ? IDLE : CALC) : IDLE;
  end
  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    if (accept) begin
      a_d   = '0;
      q_d   = dividend;
      m_d   = divisor;
      cnt_d = CW'(WIDTH);
    end
    if (state_q == CALC) begin
      a_d   = nonneg ? t : a_sh[WIDTH-1:0];
      q_d   = {q_q[WIDTH-2:0], nonneg};
      cnt_d = cnt_q - CW'(1);
      if (last) begin
        quot_d = q_d;
        rem_d  = a_d;
        dz_d   = 1'b0;
        done_d = 1'b1;
      end
    end
    if (state_q == DZERO) begin
      quot_d = '1;
      rem_d  = q_q;
      dz_d   = 1'b1;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    busy        = state_q != IDLE;
    done        = done_q;
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dz_q;
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scenario tasks with a scoreboard of expected division results.
module tb_seq_restoring_divider;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;
  exp_t sb[$];
  int   checks = 0, errors = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d);
    exp_t e;
    if (d == 0) begin
      e.q = '1; e.r = n; e.dz = 1'b1;
    end else begin
      e.q = n / d; e.r = n % d; e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d);
    dividend = n; divisor = d; start = 1'b1;
    sb.push_back(model(n, d));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b expected all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int   n;
    exp_t e;
    issue(8'd100, 8'd7);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", busy); end
    wait_done(30, n);
    checks++;
    if (n !== 8 || done !== 1'b1) begin
      errors++; $display("FAIL basic_latency: got %0d cycles (done=%0b) expected 8", n, done);
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=%0b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
      errors++;
      $display("FAIL basic_hold: got done=%0b busy=%0b q=%0d r=%0d expected done=0 busy=0 q=14 r=2",
               done, busy, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int   n;
    exp_t e;
    issue(8'd255, 8'd1);
    wait_done(30, n);
    checks++;
    if (n !== 8 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_first_latency: got %0d cycles expected 8", n);
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL b2b_first_result: got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r);
    end
    issue(8'd5, 8'd9);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || quotient !== 8'd255 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b done=%0b q=%0d r=%0d expected busy=1 done=0 q=255 r=0",
               busy, done, quotient, remainder);
    end
    wait_done(30, n);
    checks++;
    if (n !== 8 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_second_latency: got %0d cycles expected 8", n);
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
      errors++;
      $display("FAIL b2b_second_result: got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=%0b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_div_zero;
    int   n;
    exp_t e;
    issue(8'd200, 8'd0);
    wait_done(30, n);
    checks++;
    if (n !== 1 || done !== 1'b1) begin
      errors++; $display("FAIL dz_latency: got %0d cycles expected 1", n);
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
      errors++;
      $display("FAIL dz_result: got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=%0b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    @(posedge clk); #1;
    issue(8'd50, 8'd5);
    wait_done(30, n);
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear: got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=0",
               quotient, remainder, div_by_zero, e.q, e.r);
    end
  endtask

  task automatic test_start_ignored;
    int   n, pulses;
    exp_t e;
    issue(8'd100, 8'd7);
    n = 0;
    while (!done && n < 30) begin
      dividend = W'($urandom); divisor = W'($urandom); start = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++;
    if (n !== 8) begin errors++; $display("FAIL ignore_latency: got %0d cycles expected 8", n); end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL ignore_result: got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r);
    end
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_extra_done: got %0d extra pulses busy=%0b expected 0 and 0", pulses, busy);
    end
  endtask

  task automatic test_reset_abort;
    int   n, pulses;
    exp_t e;
    issue(8'd200, 8'd13);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b expected all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", pulses); end
    issue(8'd200, 8'd13);
    wait_done(30, n);
    e = sb.pop_front();
    checks++;
    if (n !== 8 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL abort_fresh: got %0d cycles q=%0d r=%0d expected 8 cycles q=%0d r=%0d",
               n, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_random;
    int           n;
    exp_t         e;
    logic [W-1:0] a, d;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: a = 8'd0;  1: a = 8'd1;  2: a = 8'd255;  default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: d = 8'd0;  1: d = 8'd1;  2: d = 8'd255;  default: d = W'($urandom);
      endcase
      issue(a, d);
      wait_done(30, n);
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL rand_timeout: %0d/%0d got no done in %0d cycles expected done", a, d, n);
      end
      e = sb.pop_front();
      checks++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        errors++;
        $display("FAIL rand_result: %0d/%0d got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=%0b",
                 a, d, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      if (d != 0) begin
        checks++;
        if (int'(quotient) * int'(d) + int'(remainder) != int'(a) || remainder >= d) begin
          errors++;
          $display("FAIL rand_identity: %0d/%0d got q=%0d r=%0d expected q*d+r=%0d with r<d",
                   a, d, quotient, remainder, a);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
